// File: rtl/result_uart_tx_pkg.sv
// Shared definitions for the result UART transmitter: FSM encoding and default bit period.
package result_uart_tx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    localparam int unsigned DEFAULT_CLK_DIV = 434;
    localparam int unsigned BAUD_CNT_W      = 16;

endpackage

// File: rtl/result_uart_tx_if.sv
// Byte handshake between the result mux (master) and the UART transmitter (slave).
interface result_uart_tx_if;

    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);

endinterface

// File: rtl/result_uart_tx_byte_fifo.sv
// Small byte FIFO with extra-MSB pointers; the head entry is always visible on dout.
module result_uart_tx_byte_fifo #(
    parameter int unsigned FIFO_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned DEPTH = 2 ** FIFO_LOG2;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_LOG2:0] r_wr_ptr;
    logic [FIFO_LOG2:0] r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_wr_ptr[FIFO_LOG2] != r_rd_ptr[FIFO_LOG2]) &&
                   (r_wr_ptr[FIFO_LOG2-1:0] == r_rd_ptr[FIFO_LOG2-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);

    // Full is judged on registered pointers, so a same-cycle pop never admits a push.
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[FIFO_LOG2-1:0]] <= din;
    end

    assign dout = r_mem[r_rd_ptr[FIFO_LOG2-1:0]];

endmodule

// File: rtl/result_uart_tx.sv
// UART 8N1 transmitter for datapath result bytes, fed through a small FIFO.
module result_uart_tx
    import result_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int unsigned FIFO_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    result_uart_tx_if.slave    bus,
    output logic               tx,
    output logic               busy,
    output logic               overflow
);

    localparam logic [BAUD_CNT_W-1:0] BAUD_LAST = BAUD_CNT_W'(CLK_DIV - 1);

    tx_state_e             r_state, w_state_d;
    logic [BAUD_CNT_W-1:0] r_baud, w_baud_d;
    logic [2:0]            r_bit_idx, w_bit_idx_d;
    logic [7:0]            r_shreg, w_shreg_d;
    logic                  r_tx, w_tx_d;
    logic                  r_overflow;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic [7:0]            w_fifo_dout;
    logic                  w_baud_done;

    result_uart_tx_byte_fifo #(
        .FIFO_LOG2 (FIFO_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.data_valid),
        .din   (bus.data_in),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign bus.data_ready = !w_fifo_full;
    assign w_baud_done    = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_d   = r_state;
        w_shreg_d   = r_shreg;
        w_bit_idx_d = r_bit_idx;
        w_pop       = 1'b0;
        w_tx_d      = 1'b1;
        unique case (r_state)
            StIdle: begin
                if (!w_fifo_empty) begin
                    w_pop     = 1'b1;
                    w_shreg_d = w_fifo_dout;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                w_tx_d = 1'b0;
                if (w_baud_done) begin
                    w_state_d   = StData;
                    w_bit_idx_d = '0;
                end
            end
            StData: begin
                w_tx_d = r_shreg[0];
                if (w_baud_done) begin
                    w_shreg_d   = {1'b0, r_shreg[7:1]};
                    w_bit_idx_d = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_d = StStop;
                end
            end
            StStop: begin
                // Chain straight into the next start bit when more data is queued.
                if (w_baud_done) begin
                    if (!w_fifo_empty) begin
                        w_pop     = 1'b1;
                        w_shreg_d = w_fifo_dout;
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (r_state == StIdle || w_state_d != r_state || w_baud_done) begin
            w_baud_d = '0;
        end else begin
            w_baud_d = r_baud + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_baud    <= w_baud_d;
            r_bit_idx <= w_bit_idx_d;
            r_shreg   <= w_shreg_d;
            r_tx      <= w_tx_d;
            if (bus.data_valid && !bus.data_ready) r_overflow <= 1'b1;
        end
    end

    assign tx       = r_tx;
    assign overflow = r_overflow;
    assign busy     = (r_state != StIdle) || !w_fifo_empty;

endmodule

// File: tb/tb_result_uart_tx.sv
// Scoreboard bench: accepted bytes are queued, a UART decoder per DUT pops and compares.
module tb_result_uart_tx;

    logic clk;
    logic reset;
    logic tx4, busy4, ovf4;
    logic tx2, busy2, ovf2;
    wire [1:0] tx_w = {tx2, tx4};

    int n_checks = 0;
    int n_err    = 0;
    int rst_cnt  = 0;

    logic [7:0] exp4_q[$];
    logic [7:0] exp2_q[$];
    int         starts4[$];

    result_uart_tx_if u4 ();
    result_uart_tx_if u2 ();

    result_uart_tx #(.CLK_DIV(4), .FIFO_LOG2(2)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .bus      (u4),
        .tx       (tx4),
        .busy     (busy4),
        .overflow (ovf4)
    );

    result_uart_tx #(.CLK_DIV(2), .FIFO_LOG2(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .bus      (u2),
        .tx       (tx2),
        .busy     (busy2),
        .overflow (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge reset) rst_cnt++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Decodes frames on tx_w[id]; frames cut short by a reset are discarded.
    task automatic mon(input int id, input int d);
        logic [7:0] b;
        logic       s0, sp;
        int         cnt, t0, prev, rs;
        cnt  = 0;
        prev = -1;
        forever begin
            @(negedge clk); cnt++;
            if (!reset && tx_w[id] === 1'b0) begin
                t0 = cnt;
                rs = rst_cnt;
                if (id == 0) starts4.push_back(t0);
                repeat (d / 2) begin @(negedge clk); cnt++; end
                s0 = tx_w[id];
                for (int i = 0; i < 8; i++) begin
                    repeat (d) begin @(negedge clk); cnt++; end
                    b[i] = tx_w[id];
                end
                repeat (d) begin @(negedge clk); cnt++; end
                sp = tx_w[id];
                if (rs == rst_cnt) begin
                    check(id == 0 ? "start_bit4" : "start_bit2", int'(s0), 0);
                    check(id == 0 ? "stop_bit4" : "stop_bit2", int'(sp), 1);
                    if (id == 1 && prev >= 0) check("frame_len2", int'((t0 - prev) >= 20), 1);
                    if (id == 0 && exp4_q.size() > 0) begin
                        check("data4", int'(b), int'(exp4_q.pop_front()));
                    end else if (id == 1 && exp2_q.size() > 0) begin
                        check("data2", int'(b), int'(exp2_q.pop_front()));
                    end else begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_frame%0d: got 0x%0h expected none", id, b);
                    end
                    prev = t0;
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0, 4);
            mon(1, 2);
        join_none
    end

    // Called just after a negedge; acceptance is known from the registered ready.
    task automatic put(input int id, input logic [7:0] b, output bit acc);
        if (id == 0) begin
            u4.data_in    = b;
            u4.data_valid = 1'b1;
            acc           = u4.data_ready;
            if (acc) exp4_q.push_back(b);
        end else begin
            u2.data_in    = b;
            u2.data_valid = 1'b1;
            acc           = u2.data_ready;
            if (acc) exp2_q.push_back(b);
        end
    endtask

    task automatic drain(input int id, input int limit);
        int n;
        n = 0;
        while (n < limit && ((id == 0) ? (exp4_q.size() != 0 || busy4)
                                       : (exp2_q.size() != 0 || busy2))) begin
            @(negedge clk);
            n++;
        end
        check(id == 0 ? "drain4_in_time" : "drain2_in_time", int'(n < limit), 1);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         acc;
        bit         exp_acc [6];
        logic [7:0] six [6];
        logic [7:0] b;
        int         gap, tries;

        reset         = 1'b1;
        u4.data_in    = '0;
        u4.data_valid = 1'b0;
        u2.data_in    = '0;
        u2.data_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle4", int'({tx4, u4.data_ready, busy4, ovf4}), 4'b1100);
            check("idle2", int'({tx2, u2.data_ready, busy2, ovf2}), 4'b1100);
        end

        // Single byte: 2-cycle latency, 40-cycle frame
        put(0, 8'hA5, acc);
        check("a5_accept", int'(acc), 1);
        @(negedge clk);
        u4.data_valid = 1'b0;
        check("a5_lat_a", int'(tx4), 1);
        @(negedge clk);
        check("a5_lat_b", int'(tx4), 1);
        @(negedge clk);
        check("a5_lat_c", int'(tx4), 0);
        check("a5_busy_start", int'(busy4), 1);
        repeat (38) @(negedge clk);
        check("a5_busy_late", int'(busy4), 1);
        @(negedge clk);
        check("a5_stop_tail", int'(tx4), 1);
        @(negedge clk);
        check("a5_busy_end", int'(busy4), 0);
        drain(0, 200);

        // Three bytes back-to-back
        starts4.delete();
        put(0, 8'h00, acc);
        check("b2b_acc0", int'(acc), 1);
        @(negedge clk);
        put(0, 8'hFF, acc);
        check("b2b_acc1", int'(acc), 1);
        @(negedge clk);
        put(0, 8'h3C, acc);
        check("b2b_acc2", int'(acc), 1);
        @(negedge clk);
        u4.data_valid = 1'b0;
        drain(0, 400);
        check("b2b_frames", starts4.size(), 3);
        if (starts4.size() >= 3) begin
            check("b2b_gap01", starts4[1] - starts4[0], 40);
            check("b2b_gap12", starts4[2] - starts4[1], 40);
        end

        // Six bytes into a depth-4 FIFO: the sixth overflows
        six     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_acc = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            put(0, six[i], acc);
            check("ovf_accept", int'(acc), int'(exp_acc[i]));
            @(negedge clk);
        end
        u4.data_valid = 1'b0;
        check("ovf_ready_low", int'(u4.data_ready), 0);
        check("ovf_flag", int'(ovf4), 1);
        drain(0, 600);
        check("ovf_sticky", int'(ovf4), 1);

        // Asynchronous reset mid-frame
        put(0, 8'h81, acc);
        check("rst_accept", int'(acc), 1);
        @(negedge clk);
        u4.data_valid = 1'b0;
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_tx", int'(tx4), 1);
        check("rst_busy", int'(busy4), 0);
        check("rst_ready", int'(u4.data_ready), 1);
        check("rst_ovf", int'(ovf4), 0);
        exp4_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        put(0, 8'h42, acc);
        check("post_rst_accept", int'(acc), 1);
        @(negedge clk);
        u4.data_valid = 1'b0;
        drain(0, 200);

        // Minimum divider, 20 bytes with random gaps
        for (int i = 0; i < 20; i++) begin
            gap           = $urandom_range(0, 3);
            b             = 8'($urandom);
            u2.data_valid = 1'b0;
            repeat (gap) @(negedge clk);
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 200) begin
                put(1, b, acc);
                @(negedge clk);
                tries++;
            end
            check("rnd_accept", int'(acc), 1);
        end
        u2.data_valid = 1'b0;
        drain(1, 1000);

        check("exp4_empty", exp4_q.size(), 0);
        check("exp2_empty", exp2_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
